vga_framebuffer: RTL and testbench

- Pixel source that sits directly upstream of the VGA timing/colour-output stage.
- Holds a 160x120, 12-bit RGB444 frame store; each stored pixel is shown as a 4x4 block on the 640x480 raster.
- The display side looks up the colour for the timing stage's h_addr/v_addr and returns it on vga_data.
- A host-side write port (valid/ready) updates single pixels; a hardware clear engine fills the whole store with one colour.

---
 rtl/vga_framebuffer.sv | 148 ++++++++++++++
 tb/tb_vga_framebuffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer.sv
// 160x120 RGB444 frame store scaled 4x onto a 640x480 raster, with a host
// pixel-write port and a hardware full-screen clear engine.
module vga_framebuffer #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    output logic [11:0] vga_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [11:0] wr_color,
    input  logic        clr_req,
    input  logic [11:0] clr_color,
    output logic        clr_busy
);

    localparam int          DEPTH     = FB_W * FB_H;
    localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [7:0]  FB_W_L    = 8'(FB_W);
    localparam logic [6:0]  FB_H_L    = 7'(FB_H);
    localparam logic [9:0]  H_ACT_L   = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_L   = 10'(V_ACTIVE);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] clr_ptr_q, clr_ptr_d;
    logic [11:0] clr_color_q, clr_color_d;

    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_data;

    logic [11:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Display read path: one-cycle synchronous lookup, blank flag alongside
    // ------------------------------------------------------------------
    logic        rd_blank;
    logic [14:0] rd_x, rd_y, rd_addr;
    logic [11:0] rd_data_q;
    logic        blank_q;

    // Row stride of 160 is built from two shifts: y*128 + y*32.
    always_comb begin
        rd_blank = (h_addr >= H_ACT_L) || (v_addr >= V_ACT_L);
        rd_x     = 15'(h_addr >> SCALE_SHIFT);
        rd_y     = 15'(v_addr >> SCALE_SHIFT);
        rd_addr  = rd_blank ? 15'd0 : (rd_y << 7) + (rd_y << 5) + rd_x;
    end

    // NOTE: RAM has no reset so it maps onto block memory; only the blank
    // flag needs a reset value to force vga_data to black.
    always_ff @(posedge clk) begin
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= 1'b1;
        end else begin
            blank_q <= rd_blank;
        end
    end

    assign vga_data = blank_q ? 12'h000 : rd_data_q;

    // ------------------------------------------------------------------
    // Clear FSM and write-port arbitration
    // ------------------------------------------------------------------
    logic        wr_in_range;
    logic [14:0] wr_addr;

    assign wr_in_range = (wr_x < FB_W_L) && (wr_y < FB_H_L);
    assign wr_addr     = (15'(wr_y) << 7) + (15'(wr_y) << 5) + 15'(wr_x);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            clr_ptr_q   <= 15'd0;
            clr_color_q <= 12'h000;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_color_q <= clr_color_d;
        end
    end

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_color_d = clr_color_q;
        wr_ready    = 1'b0;
        clr_busy    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = wr_addr;
        mem_data    = wr_color;

        case (state_q)
            IDLE: begin
                wr_ready = 1'b1;
                // Out-of-range beats complete the handshake but touch nothing.
                mem_we   = wr_valid && wr_in_range;
                if (clr_req) begin
                    state_d     = CLEAR;
                    clr_ptr_d   = 15'd0;
                    clr_color_d = clr_color;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_ptr_q;
                mem_data = clr_color_q;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_ptr_d = 15'd0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 15'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Scoreboard bench for vga_framebuffer: read expectations are queued by the
// stimulus and popped by an independent monitor one cycle later.
module tb_vga_framebuffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  h_addr = 10'd640;
    logic [9:0]  v_addr = 10'd0;
    logic [11:0] vga_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  wr_x = 8'd0;
    logic [6:0]  wr_y = 7'd0;
    logic [11:0] wr_color = 12'h000;
    logic        clr_req = 1'b0;
    logic [11:0] clr_color = 12'h000;
    logic        clr_busy;

    logic        rd_req = 1'b0;

    typedef struct {
        logic [11:0] data;
        int          h;
        int          v;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    vga_framebuffer dut (
        .clk       (clk),
        .rst       (rst),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .vga_data  (vga_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_color  (wr_color),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .clr_busy  (clr_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any edge that sampled a requested read is compared just after.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rd_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("vga_data h=%0d v=%0d", e.h, e.v), 32'(vga_data), 32'(e.data));
                end
            end
        end
    end

    task automatic read_px(input int h, input int v, input logic [11:0] exp);
        exp_t e;
        @(negedge clk);
        h_addr = 10'(h);
        v_addr = 10'(v);
        rd_req = 1'b1;
        e.data = exp;
        e.h    = h;
        e.v    = v;
        exp_q.push_back(e);
    endtask

    task automatic end_reads();
        @(negedge clk);
        rd_req = 1'b0;
        h_addr = 10'd640;
    endtask

    task automatic host_write(input int x, input int y, input logic [11:0] c);
        @(negedge clk);
        wr_x     = 8'(x);
        wr_y     = 7'(y);
        wr_color = c;
        wr_valid = 1'b1;
        check("wr_ready_on_offer", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called on the first negedge after the clear-starting edge.
    task automatic measure_clear(input string tag, input int hold);
        int n   = 0;
        int bad = 0;
        while (clr_busy && n < 20000) begin
            n++;
            if (wr_ready) bad++;
            if (n == hold) clr_req = 1'b0;
            @(negedge clk);
        end
        clr_req = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'd19200);
        check({tag, "_ready_during_clear"}, 32'(bad), 32'd0);
    endtask

    task automatic start_clear(input logic [11:0] c);
        @(negedge clk);
        clr_req   = 1'b1;
        clr_color = c;
        @(negedge clk);
        check("clr_busy_after_req", 32'(clr_busy), 32'd1);
    endtask

    initial begin
        // Reset held five cycles
        repeat (5) @(negedge clk);
        check("reset_vga_data", 32'(vga_data), 32'h000);
        check("reset_clr_busy", 32'(clr_busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_vga_data", 32'(vga_data), 32'h000);
        check("idle_clr_busy", 32'(clr_busy), 32'd0);
        check("idle_wr_ready", 32'(wr_ready), 32'd1);

        // Reset in the middle of a clear aborts it at once
        start_clear(12'hABC);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midclear_reset_busy", 32'(clr_busy), 32'd0);
        check("midclear_reset_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Clear to green with clr_req held well into CLEAR: no restart
        start_clear(12'h0F0);
        measure_clear("clear_green", 100);
        check("clear_green_wr_ready_after", 32'(wr_ready), 32'd1);
        @(negedge clk);
        check("clear_green_no_restart", 32'(clr_busy), 32'd0);

        // Blanking and raster corners
        read_px(639, 479, 12'h0F0);
        read_px(640, 100, 12'h000);
        read_px(100, 480, 12'h000);
        read_px(0, 0, 12'h0F0);
        read_px(1023, 1023, 12'h000);
        end_reads();

        // Single write replicated over a 4x4 block
        host_write(10, 5, 12'hF00);
        for (int v = 20; v < 24; v++) begin
            for (int h = 40; h < 44; h++) begin
                read_px(h, v, 12'hF00);
            end
        end
        read_px(44, 20, 12'h0F0);
        read_px(39, 20, 12'h0F0);
        read_px(40, 24, 12'h0F0);
        end_reads();

        // Out-of-range writes complete but change nothing
        host_write(160, 0, 12'hFFF);
        host_write(0, 120, 12'hFFF);
        read_px(0, 4, 12'h0F0);
        read_px(0, 0, 12'h0F0);
        read_px(40, 20, 12'hF00);
        read_px(636, 476, 12'h0F0);
        end_reads();

        // Write and clear request in the same IDLE cycle
        @(negedge clk);
        clr_req   = 1'b1;
        clr_color = 12'h00F;
        wr_valid  = 1'b1;
        wr_x      = 8'd0;
        wr_y      = 7'd0;
        wr_color  = 12'hFFF;
        check("concurrent_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        check("concurrent_busy", 32'(clr_busy), 32'd1);
        // Hold a new write across the whole clear; it must wait for IDLE
        wr_x     = 8'd1;
        wr_color = 12'h123;
        measure_clear("clear_blue", 1);
        check("held_write_ready_after", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;

        read_px(0, 0, 12'h00F);
        read_px(4, 0, 12'h123);
        read_px(7, 3, 12'h123);
        read_px(40, 20, 12'h00F);
        read_px(639, 479, 12'h00F);

        // Read-first: same-cycle read of the written address sees old data
        @(negedge clk);
        begin
            exp_t e;
            h_addr = 10'd8;
            v_addr = 10'd0;
            e.data = 12'h00F;
            e.h    = 8;
            e.v    = 0;
            exp_q.push_back(e);
            wr_valid = 1'b1;
            wr_x     = 8'd2;
            wr_y     = 7'd0;
            wr_color = 12'h456;
            @(negedge clk);
            wr_valid = 1'b0;
            e.data   = 12'h456;
            exp_q.push_back(e);
        end
        end_reads();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
